// File: rtl/tcdm_region_filter_ooq.sv
// Programmable TCDM region filter: forwards permitted requests, answers blocked ones with ERR_RDATA, keeps responses in request order.
// Define TCDM_FILTER_PERM_EN to enforce per-rule R/W permissions; otherwise a valid rule grants both.
module tcdm_region_filter_ooq #(
  parameter int unsigned N_RULES         = 8,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH/8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_RDATA       = 32'hBADE5505
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  supervisor_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_WIDTH-1:0] add_o,
  output logic                  wen_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [BE_WIDTH-1:0]   be_o,
  input  logic                  r_valid_i,
  input  logic [DATA_WIDTH-1:0] r_rdata_i,
  input  logic                  cfg_req_i,
  input  logic                  cfg_we_i,
  input  logic [7:0]            cfg_addr_i,
  input  logic [31:0]           cfg_wdata_i,
  output logic [31:0]           cfg_rdata_o,
  output logic                  error_o
);
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam logic [7:0] GCTRL_A    = 8'(4*N_RULES);
  localparam logic [7:0] ERR_ADDR_A = 8'(4*N_RULES + 1);
  localparam logic [7:0] ERR_INFO_A = 8'(4*N_RULES + 2);

  logic [ADDR_WIDTH-1:0] start_q [N_RULES];
  logic [ADDR_WIDTH-1:0] end_q   [N_RULES];
  logic [N_RULES-1:0]    v_q;
`ifdef TCDM_FILTER_PERM_EN
  logic [N_RULES-1:0]    r_q, w_q;
`endif
  logic                  en_q, lock_q;
  logic                  err_vld_q, err_wen_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [15:0]           err_cnt_q;
  logic [31:0]           cfg_rdata_q, rd_d;

  logic [MAX_OUTSTANDING-1:0] qerr_q, qdvld_q;
  logic [DATA_WIDTH-1:0]      qdata_q [MAX_OUTSTANDING];
  logic [PW-1:0]              head_q, tail_q, scan_idx, fill_idx;
  logic [CW-1:0]              cnt_q;
  logic                       hit, allowed, full, push, pop, fill_hit;
  logic                       cfg_wr, err_clr;
  logic [5:0]                 cfg_idx;
  logic [1:0]                 cfg_sub;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_RULES; i++) begin
      if (v_q[i] && (add_i >= start_q[i]) && (add_i < end_q[i])) begin
`ifdef TCDM_FILTER_PERM_EN
        if (wen_i ? r_q[i] : w_q[i]) hit = 1'b1;
`else
        hit = 1'b1;
`endif
      end
    end
  end

  assign allowed   = supervisor_i | ~en_q | hit;
  assign full      = (cnt_q == CW'(MAX_OUTSTANDING));
  assign req_o     = ~rst & allowed & req_i & ~full;
  assign gnt_o     = ~rst & ~full & (allowed ? gnt_i : 1'b1);
  assign error_o   = ~rst & ~allowed & req_i & ~full;
  assign push      = req_i & gnt_o;
  assign pop       = ~rst & (cnt_q != '0) & (qerr_q[head_q] | qdvld_q[head_q]);
  assign r_valid_o = pop;
  assign r_rdata_o = pop ? (qerr_q[head_q] ? {(DATA_WIDTH/32){ERR_RDATA}} : qdata_q[head_q])
                         : '0;
  assign add_o     = rst ? '0 : add_i;
  assign wen_o     = ~rst & wen_i;
  assign wdata_o   = rst ? '0 : wdata_i;
  assign be_o      = rst ? '0 : be_i;

  // Downstream responses are in order, so they belong to the oldest forwarded entry still waiting.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head_q;
    scan_idx = head_q;
    for (int k = 0; k < MAX_OUTSTANDING; k++) begin
      scan_idx = head_q + PW'(k);
      if (!fill_hit && (CW'(k) < cnt_q) && !qerr_q[scan_idx] && !qdvld_q[scan_idx]) begin
        fill_hit = 1'b1;
        fill_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      qerr_q  <= '0;
      qdvld_q <= '0;
      for (int k = 0; k < MAX_OUTSTANDING; k++) qdata_q[k] <= '0;
    end else begin
      if (push) begin
        qerr_q[tail_q]  <= ~allowed;
        qdvld_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + PW'(1);
      end
      if (r_valid_i && fill_hit) begin
        qdvld_q[fill_idx] <= 1'b1;
        qdata_q[fill_idx] <= r_rdata_i;
      end
      if (pop) head_q <= head_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign cfg_wr  = cfg_req_i & cfg_we_i;
  assign cfg_idx = cfg_addr_i[7:2];
  assign cfg_sub = cfg_addr_i[1:0];
  assign err_clr = cfg_wr & (cfg_addr_i == ERR_INFO_A);

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < N_RULES; i++) begin
      if (cfg_idx == 6'(i)) begin
        case (cfg_sub)
          2'd0: rd_d[ADDR_WIDTH-1:0] = start_q[i];
          2'd1: rd_d[ADDR_WIDTH-1:0] = end_q[i];
`ifdef TCDM_FILTER_PERM_EN
          2'd2: rd_d[2:0] = {w_q[i], r_q[i], v_q[i]};
`else
          2'd2: rd_d[0] = v_q[i];
`endif
          default: rd_d = '0;
        endcase
      end
    end
    if (cfg_addr_i == GCTRL_A)    rd_d = {30'b0, lock_q, en_q};
    if (cfg_addr_i == ERR_ADDR_A) rd_d[ADDR_WIDTH-1:0] = err_addr_q;
    if (cfg_addr_i == ERR_INFO_A) rd_d = {err_cnt_q, 14'b0, err_wen_q, err_vld_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_RULES; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
      end
      v_q         <= '0;
`ifdef TCDM_FILTER_PERM_EN
      r_q         <= '0;
      w_q         <= '0;
`endif
      en_q        <= 1'b0;
      lock_q      <= 1'b0;
      err_vld_q   <= 1'b0;
      err_wen_q   <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
      cfg_rdata_q <= '0;
    end else begin
      if (cfg_req_i && !cfg_we_i) cfg_rdata_q <= rd_d;
      for (int i = 0; i < N_RULES; i++) begin
        if (cfg_wr && !lock_q && (cfg_idx == 6'(i))) begin
          case (cfg_sub)
            2'd0: start_q[i] <= cfg_wdata_i[ADDR_WIDTH-1:0];
            2'd1: end_q[i]   <= cfg_wdata_i[ADDR_WIDTH-1:0];
            2'd2: begin
              v_q[i] <= cfg_wdata_i[0];
`ifdef TCDM_FILTER_PERM_EN
              r_q[i] <= cfg_wdata_i[1];
              w_q[i] <= cfg_wdata_i[2];
`endif
            end
            default: ;
          endcase
        end
      end
      if (cfg_wr && !lock_q && (cfg_addr_i == GCTRL_A)) begin
        en_q   <= cfg_wdata_i[0];
        lock_q <= cfg_wdata_i[1];
      end
      // A fault coinciding with a clear is recorded as the first fault of a fresh window.
      if (error_o) begin
        if (!err_vld_q || err_clr) begin
          err_vld_q  <= 1'b1;
          err_addr_q <= add_i;
          err_wen_q  <= wen_i;
        end
        if (err_clr)                   err_cnt_q <= 16'd1;
        else if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (err_clr) begin
        err_vld_q  <= 1'b0;
        err_wen_q  <= 1'b0;
        err_addr_q <= '0;
        err_cnt_q  <= '0;
      end
    end
  end

  assign cfg_rdata_o = cfg_rdata_q;

endmodule

// File: tb/tb_tcdm_region_filter_ooq.sv
// Bench for tcdm_region_filter_ooq: directed scenarios plus randomized traffic against a queue-level reference model.
module tb_tcdm_region_filter_ooq;
  localparam logic [31:0] ERRW = 32'hBADE5505;
  localparam logic [7:0]  GCTRL_A = 8'd32, ERR_ADDR_A = 8'd33, ERR_INFO_A = 8'd34;

  logic        clk = 1'b0, rst = 1'b1;
  logic        supervisor_i = 0, req_i = 0, gnt_o, wen_i = 0;
  logic [31:0] add_i = 0, wdata_i = 0, r_rdata_o, add_o, wdata_o, r_rdata_i = 0;
  logic [3:0]  be_i = 0, be_o;
  logic        r_valid_o, req_o, gnt_i = 0, wen_o, r_valid_i = 0;
  logic        cfg_req_i = 0, cfg_we_i = 0, error_o;
  logic [7:0]  cfg_addr_i = 0;
  logic [31:0] cfg_wdata_i = 0, cfg_rdata_o;

  int errors = 0, checks = 0;

  typedef struct {bit err; bit dv; logic [31:0] d;} ent_t;
  logic [31:0] rs [4], re [4], rc [4];

  tcdm_region_filter_ooq dut (
    .clk(clk), .rst(rst), .supervisor_i(supervisor_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
    .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .req_o(req_o), .gnt_i(gnt_i),
    .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req_i = 0; gnt_i = 0; wen_i = 0; add_i = 0; supervisor_i = 0;
    r_valid_i = 0; r_rdata_i = 0; cfg_req_i = 0; cfg_we_i = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d);
    cfg_req_i = 1; cfg_we_i = 1; cfg_addr_i = a; cfg_wdata_i = d;
    tick();
    cfg_req_i = 0; cfg_we_i = 0;
  endtask

  task automatic cfg_rd(input logic [7:0] a, output logic [31:0] d);
    cfg_req_i = 1; cfg_we_i = 0; cfg_addr_i = a;
    tick();
    cfg_req_i = 0;
    d = cfg_rdata_o;
  endtask

  // Reference permission check: plain range test over the bench's own copy of the rule table.
  function automatic bit model_allowed(input logic [31:0] a, input bit wr);
    bit ok = 0;
    for (int i = 0; i < 4; i++) begin
      if (rc[i][0] && a >= rs[i] && a < re[i]) begin
`ifdef TCDM_FILTER_PERM_EN
        if (wr ? rc[i][2] : rc[i][1]) ok = 1;
`else
        ok = 1;
`endif
      end
    end
    return ok;
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    rst = 1; req_i = 1; gnt_i = 1; add_i = 32'h1234; wen_i = 1;
    tick(); #1;
    checks++; if (gnt_o !== 1'b0 || req_o !== 1'b0 || error_o !== 1'b0 || add_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got gnt=%b req=%b err=%b add=%h want 0", gnt_o, req_o, error_o, add_o); end
    checks++; if (r_valid_o !== 1'b0 || r_rdata_o !== 32'h0 || cfg_rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_resp got rv=%b rd=%h cfg=%h want 0", r_valid_o, r_rdata_o, cfg_rdata_o); end
    do_reset();
    cfg_rd(GCTRL_A, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_gctrl got %h want 0", d); end
    cfg_rd(ERR_INFO_A, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_errinfo got %h want 0", d); end
    cfg_rd(8'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rctrl got %h want 0", d); end
  endtask

  task automatic test_passthrough;
    bit erv;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_i = (c < 4); add_i = 32'h1C000000 + 32'(4*c); wen_i = 1; gnt_i = 1;
      r_valid_i = (c >= 2 && c < 6); r_rdata_i = 32'hD0000000 + 32'(c - 2);
      #1;
      erv = (c >= 3 && c < 7);
      checks++; if (req_o !== (c < 4) || (c < 4 && add_o !== add_i)) begin
        errors++; $display("FAIL pass_req c=%0d got req=%b add=%h want req=%b", c, req_o, add_o, c < 4); end
      checks++; if (r_valid_o !== erv || (erv && r_rdata_o !== 32'hD0000000 + 32'(c - 3))) begin
        errors++; $display("FAIL pass_resp c=%0d got rv=%b rd=%h want rv=%b rd=%h", c, r_valid_o, r_rdata_o, erv, 32'hD0000000 + 32'(c - 3)); end
      tick();
    end
    idle();
  endtask

  task automatic setup_rule0_r;
    cfg_wr(8'd0, 32'h1C000000);
    cfg_wr(8'd1, 32'h1C010000);
    cfg_wr(8'd2, 32'h3);
    cfg_wr(GCTRL_A, 32'h1);
  endtask

  task automatic test_blocked;
    logic [31:0] d;
    do_reset(); setup_rule0_r();
    req_i = 1; add_i = 32'h1C020000; wen_i = 1; gnt_i = 1; #1;
    checks++; if (req_o !== 0 || error_o !== 1 || gnt_o !== 1) begin
      errors++; $display("FAIL blk_issue got req=%b err=%b gnt=%b want 0 1 1", req_o, error_o, gnt_o); end
    tick(); req_i = 0; gnt_i = 0; #1;
    checks++; if (r_valid_o !== 1 || r_rdata_o !== ERRW || error_o !== 0) begin
      errors++; $display("FAIL blk_resp got rv=%b rd=%h err=%b want 1 %h 0", r_valid_o, r_rdata_o, error_o, ERRW); end
    tick();
    checks++; if (r_valid_o !== 0) begin errors++; $display("FAIL blk_resp_once got rv=%b want 0", r_valid_o); end
    req_i = 1; add_i = 32'h1C00FFFC; #1;
    checks++; if (req_o !== 1 || error_o !== 0 || gnt_o !== 0) begin
      errors++; $display("FAIL blk_last_word got req=%b err=%b gnt=%b want 1 0 0", req_o, error_o, gnt_o); end
    add_i = 32'h1C000000; #1;
    checks++; if (req_o !== 1) begin errors++; $display("FAIL blk_start got req=%b want 1", req_o); end
    add_i = 32'h1C010000; #1;
    checks++; if (req_o !== 0 || error_o !== 1) begin
      errors++; $display("FAIL blk_end_excl got req=%b err=%b want 0 1", req_o, error_o); end
    add_i = 32'h1BFFFFFC; wen_i = 0; #1;
    tick(); idle();
    cfg_rd(ERR_ADDR_A, d);
    checks++; if (d !== 32'h1C020000) begin errors++; $display("FAIL blk_erraddr got %h want 1c020000", d); end
    cfg_rd(ERR_INFO_A, d);
    checks++; if (d !== 32'h00020003) begin errors++; $display("FAIL blk_errinfo got %h want 00020003", d); end
    cfg_wr(ERR_INFO_A, 32'h0);
    cfg_rd(ERR_INFO_A, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL blk_errclr got %h want 0", d); end
    // fault in the same cycle as a clear restarts the count at one
    req_i = 1; add_i = 32'h1C030000; wen_i = 0;
    cfg_wr(ERR_INFO_A, 32'h0);
    idle();
    cfg_rd(ERR_INFO_A, d);
    checks++; if (d !== 32'h00010001) begin errors++; $display("FAIL blk_clr_race got %h want 00010001", d); end
  endtask

  task automatic test_order;
    bit erv;
    logic [31:0] erd;
    do_reset(); setup_rule0_r();
    for (int c = 0; c < 10; c++) begin
      req_i = (c < 2); add_i = (c == 0) ? 32'h1C000100 : 32'h1C020000; wen_i = 1; gnt_i = 1;
      r_valid_i = (c == 5); r_rdata_i = 32'h12345678;
      #1;
      erv = (c == 6 || c == 7);
      erd = (c == 6) ? 32'h12345678 : ERRW;
      checks++; if (r_valid_o !== erv || (erv && r_rdata_o !== erd)) begin
        errors++; $display("FAIL order c=%0d got rv=%b rd=%h want rv=%b rd=%h", c, r_valid_o, r_rdata_o, erv, erd); end
      tick();
    end
    idle();
  endtask

  task automatic test_full;
    bit eg;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_i = 1; add_i = 32'h100 + 32'(c); wen_i = 1; gnt_i = 1;
      r_valid_i = (c == 4); r_rdata_i = 32'hCAFE0000;
      #1;
      eg = (c < 4) || (c == 6);
      checks++; if (gnt_o !== eg || req_o !== eg) begin
        errors++; $display("FAIL full_gnt c=%0d got gnt=%b req=%b want %b", c, gnt_o, req_o, eg); end
      checks++; if (r_valid_o !== (c == 5) || (c == 5 && r_rdata_o !== 32'hCAFE0000)) begin
        errors++; $display("FAIL full_resp c=%0d got rv=%b rd=%h want rv=%b", c, r_valid_o, r_rdata_o, c == 5); end
      tick();
    end
    req_i = 0; r_valid_i = 0;
    rst = 1; tick(); rst = 0;
    r_valid_i = 1; r_rdata_i = 32'h5555AAAA;
    tick(); r_valid_i = 0; #1;
    checks++; if (r_valid_o !== 0 || gnt_o !== 1) begin
      errors++; $display("FAIL full_flush got rv=%b gnt=%b want 0 1", r_valid_o, gnt_o); end
    idle();
  endtask

  task automatic test_perm;
    logic [31:0] d;
    bit pe;
`ifdef TCDM_FILTER_PERM_EN
    pe = 1;
`else
    pe = 0;
`endif
    do_reset(); setup_rule0_r();
    cfg_wr(8'd4, 32'h20000000); cfg_wr(8'd5, 32'h20001000); cfg_wr(8'd6, 32'h5);
    req_i = 1; gnt_i = 0; add_i = 32'h1C000010; wen_i = 0; #1;
    checks++; if (req_o !== !pe || error_o !== pe) begin
      errors++; $display("FAIL perm_write_ronly got req=%b err=%b want %b %b", req_o, error_o, !pe, pe); end
    tick();
    wen_i = 1; #1;
    checks++; if (req_o !== 1 || error_o !== 0) begin
      errors++; $display("FAIL perm_read_ronly got req=%b err=%b want 1 0", req_o, error_o); end
    add_i = 32'h20000000; #1;
    checks++; if (req_o !== !pe || error_o !== pe) begin
      errors++; $display("FAIL perm_read_wonly got req=%b err=%b want %b %b", req_o, error_o, !pe, pe); end
    tick();
    supervisor_i = 1; add_i = 32'h00000040; wen_i = 0; #1;
    checks++; if (req_o !== 1 || error_o !== 0) begin
      errors++; $display("FAIL perm_supervisor got req=%b err=%b want 1 0", req_o, error_o); end
    tick(); idle();
    cfg_rd(8'd2, d);
    checks++; if (d !== (pe ? 32'h3 : 32'h1)) begin
      errors++; $display("FAIL perm_rctrl_rb got %h want %h", d, pe ? 32'h3 : 32'h1); end
  endtask

  task automatic test_lock;
    logic [31:0] d;
    do_reset();
    cfg_wr(8'd0, 32'h1000);
    cfg_wr(GCTRL_A, 32'h3);
    cfg_wr(8'd0, 32'h2000);
    cfg_wr(GCTRL_A, 32'h0);
    cfg_rd(8'd0, d);
    checks++; if (d !== 32'h1000) begin errors++; $display("FAIL lock_start got %h want 1000", d); end
    cfg_rd(GCTRL_A, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL lock_gctrl got %h want 3", d); end
    cfg_rd(8'd60, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h want 0", d); end
    do_reset();
    cfg_rd(GCTRL_A, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_rst_gctrl got %h want 0", d); end
    cfg_wr(8'd0, 32'h2000);
    cfg_rd(8'd0, d);
    checks++; if (d !== 32'h2000) begin errors++; $display("FAIL lock_rst_write got %h want 2000", d); end
  endtask

  task automatic test_random;
    ent_t mq [$];
    logic [31:0] pool [10];
    logic [31:0] d, first_addr, erd;
    int pend, ecnt, c;
    bit alw, full, ereq, egnt, eerr, erv, filled;
    pool = '{32'h0FFC, 32'h1000, 32'h1FFC, 32'h2000, 32'h3000,
             32'h37FC, 32'h3800, 32'h4400, 32'h5000, 32'h4800};
    rs = '{32'h1000, 32'h3000, 32'h4000, 32'h5000};
    re = '{32'h2000, 32'h3800, 32'h4800, 32'h4000};
    rc = '{32'h7, 32'h3, 32'h6, 32'h7};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cfg_wr(8'(4*i), rs[i]); cfg_wr(8'(4*i+1), re[i]); cfg_wr(8'(4*i+2), rc[i]);
    end
    cfg_wr(GCTRL_A, 32'h1);
    pend = 0; ecnt = 0; first_addr = 0; c = 0;
    while ((c < 500 || mq.size() > 0) && c < 3000) begin
      req_i = (c < 500) && ($urandom_range(3) != 0);
      add_i = pool[$urandom_range(9)];
      wen_i = 1'($urandom_range(1));
      supervisor_i = ($urandom_range(7) == 0);
      gnt_i = 1'($urandom_range(1));
      r_valid_i = (pend > 0) && ($urandom_range(2) == 0);
      r_rdata_i = $urandom;
      #1;
      alw  = supervisor_i || model_allowed(add_i, !wen_i);
      full = (mq.size() == 4);
      ereq = req_i && alw && !full;
      egnt = !full && (alw ? gnt_i : 1'b1);
      eerr = req_i && !alw && !full;
      erv  = (mq.size() > 0) && (mq[0].err || mq[0].dv);
      erd  = (erv && mq[0].err) ? ERRW : ((mq.size() > 0) ? mq[0].d : 32'h0);
      checks++; if (req_o !== ereq) begin errors++; $display("FAIL rnd_req c=%0d got %b want %b", c, req_o, ereq); end
      checks++; if (gnt_o !== egnt) begin errors++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, gnt_o, egnt); end
      checks++; if (error_o !== eerr) begin errors++; $display("FAIL rnd_err c=%0d got %b want %b", c, error_o, eerr); end
      checks++; if (r_valid_o !== erv || (erv && r_rdata_o !== erd)) begin
        errors++; $display("FAIL rnd_resp c=%0d got rv=%b rd=%h want rv=%b rd=%h", c, r_valid_o, r_rdata_o, erv, erd); end
      if (erv) void'(mq.pop_front());
      if (r_valid_i) begin
        filled = 0;
        for (int k = 0; k < mq.size(); k++)
          if (!filled && !mq[k].err && !mq[k].dv) begin mq[k].dv = 1; mq[k].d = r_rdata_i; filled = 1; end
        pend--;
      end
      if (req_i && egnt) begin
        mq.push_back('{err: !alw, dv: 1'b0, d: 32'h0});
        if (alw) pend++;
      end
      if (eerr) begin
        if (ecnt == 0) first_addr = add_i;
        ecnt++;
      end
      tick();
      c++;
    end
    idle();
    checks++; if (mq.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout left=%0d want 0", mq.size()); end
    cfg_rd(ERR_INFO_A, d);
    checks++; if (d !== {16'(ecnt), 14'b0, d[1], ecnt > 0}) begin
      errors++; $display("FAIL rnd_errinfo got %h want cnt=%0d vld=%b", d, ecnt, ecnt > 0); end
    cfg_rd(ERR_ADDR_A, d);
    checks++; if (d !== first_addr) begin errors++; $display("FAIL rnd_erraddr got %h want %h", d, first_addr); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_blocked();
    test_order();
    test_full();
    test_perm();
    test_random();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
